mem_wb_seg_reg_v2: RTL and testbench
====================================

Name: mem_wb_seg_reg_v2

Overview:
- Parametrised MEM/WB segment register with an integrated synchronous dual-port data RAM and built-in load extension.
- Port A serves the pipeline. Port B serves the debug path.
- Supports 1- or 2-cycle RAM read latency. At latency 2, an internal stall FSM holds the stage and requests an upstream stall.
- Sits between EX and WB; replaces the fixed-width MW register plus external extension logic.

Parameters:
XLEN, 32, datapath width (32 only legal value in this revision; kept for future)
DEPTH_WORDS, 4096, RAM depth in XLEN-bit words (power of two)
ADDR_W, log2(DEPTH_WORDS), word-address width (derived, not overridden)
READ_LAT, 1, RAM read latency: 1 or 2

Ports:
clk  in  1  clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
en  in  1  stage enable from hazard unit
clear  in  1  synchronous flush of stage registers
alu_out_e  in  XLEN  address / ALU result
store_data_e  in  XLEN  store data, already lane-aligned
rd_e  in  5  destination register
pc_e  in  XLEN  PC of instruction
mem_write_e  in  4  byte write enables
reg_write_e  in  3  000 none, 001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU, 110 ALU write
mem_to_reg_e  in  1  instruction is a load
load_npc_e  in  1  write PC+4 to rd
alu_out_mw  out  XLEN  registered ALU result
rd_mw  out  5  registered rd
pc_mw  out  XLEN  registered PC
reg_write_mw  out  3  registered reg_write
mem_to_reg_mw  out  1  registered mem_to_reg
load_npc_mw  out  1  registered load_npc
load_data_mw  out  XLEN  extended load data
stall_req  out  1  request upstream freeze
a2  in  XLEN  debug byte address
wd2  in  XLEN  debug write data
we2  in  4  debug byte enables
rd2  out  XLEN  debug read data, 1-cycle latency

Behaviour:
- Reset (rst_n=0, async): all *_mw outputs 0, FSM to IDLE, stall_req 0, internal read-data pipeline 0. RAM contents are not reset.
- Port A word address: alu_out_e[ADDR_W+1:2]. Bits above ADDR_W+1 are ignored (wrap).
- Capture condition: state IDLE and en=1.
  - clear=1 has priority and zeroes all *_mw.
  - Otherwise, *_e inputs are latched into *_mw.
- RAM write: wea = mem_write_e, gated by (IDLE && en && !clear).
- RAM read is read-first: same-cycle write to the same word returns old data.
- Port B: rd2 is the registered read of a2[ADDR_W+1:2]; it is read-first.
- Simultaneous A/B write to the same word: port A data is stored per byte lane where both are enabled.
- Extension (combinational on raw RAM data, alu_out_mw[1:0], reg_write_mw):
  - LB/LBU: select byte [1:0]*8, sign- or zero-extend.
  - LH/LHU: select half alu_out_mw[1]*16, sign- or zero-extend.
  - LW: pass through.
  - Other codes: output 0.
- READ_LAT=1: load_data_mw is valid in the cycle after capture. FSM stays IDLE; stall_req is held at 0.
- READ_LAT=2: raw data passes through an extra register.
  - FSM states: IDLE, WAIT.
  - IDLE -> WAIT when a load is captured (capture condition, clear=0, mem_to_reg_e=1).
  - In WAIT: stall_req=1 (combinational from state), *_mw hold, en ignored, RAM writes blocked.
  - WAIT -> IDLE next cycle; load_data_mw is valid in that IDLE cycle.
  - clear in WAIT: zero *_mw, return to IDLE, stall_req drops the following cycle.
- Back-to-back loads at READ_LAT=2 each incur exactly one WAIT cycle.
- en=0 in IDLE: all registers hold and no RAM write occurs.

Optional Feature:
MISALIGN_TRAP_EN
- Defined:
  - Adds output misalign_mw (1 bit, reset 0).
  - Misaligned condition: a halfword access with alu_out_e[0]=1, or a word access with alu_out_e[1:0]!=0. Access type comes from reg_write_e for loads and the mem_write_e pattern for stores (0011/1100 = half, 1111 = word).
  - On a misaligned capture: RAM write is suppressed, misaligned loads do not enter WAIT, and misalign_mw=1 for the captured instruction.
- Undefined: no port; misaligned accesses proceed using the given byte enables and the lane selection above.

Test Plan:
- Reset mid-WAIT (READ_LAT=2): assert rst_n=0 during WAIT -> stall_req=0 and all *_mw=0 immediately (asynchronous).
- Store word 0xDEADBEEF at 0x10 (mem_write_e=1111), then LB at 0x13 and LBU at 0x13 -> load_data_mw = 0xFFFFFFDE, then 0x000000DE.
- LH at 0x12 after the store above -> 0xFFFFDEAD. LHU at 0x10 -> 0x0000BEEF.
- READ_LAT=2: two consecutive LW at 0x10 -> each holds stall_req=1 for exactly one cycle; both return 0xDEADBEEF; rd_mw is stable through WAIT.
- clear with en=1 and mem_write_e=1111 -> no RAM write (port B read of that address is unchanged) and all *_mw=0.
- Port B writes 0x12345678 to 0x20 while port A writes byte 0xAA to lane 0 of 0x20 -> port B read returns 0x123456AA.

Source files
------------

// File: rtl/mem_wb_seg_reg_v2_if.sv
// Pipeline and debug bus of the MEM/WB segment register.
// The misalign_mw signal exists only when MISALIGN_TRAP_EN is defined.
interface mem_wb_seg_reg_v2_if #(
  parameter int unsigned XLEN = 32
);
  logic            en;
  logic            clear;
  logic [XLEN-1:0] alu_out_e;
  logic [XLEN-1:0] store_data_e;
  logic [4:0]      rd_e;
  logic [XLEN-1:0] pc_e;
  logic [3:0]      mem_write_e;
  logic [2:0]      reg_write_e;
  logic            mem_to_reg_e;
  logic            load_npc_e;
  logic [XLEN-1:0] alu_out_mw;
  logic [4:0]      rd_mw;
  logic [XLEN-1:0] pc_mw;
  logic [2:0]      reg_write_mw;
  logic            mem_to_reg_mw;
  logic            load_npc_mw;
  logic [XLEN-1:0] load_data_mw;
  logic            stall_req;
  logic [XLEN-1:0] a2;
  logic [XLEN-1:0] wd2;
  logic [3:0]      we2;
  logic [XLEN-1:0] rd2;
`ifdef MISALIGN_TRAP_EN
  logic            misalign_mw;
`endif

  modport master (
    output en, clear, alu_out_e, store_data_e, rd_e, pc_e, mem_write_e,
           reg_write_e, mem_to_reg_e, load_npc_e, a2, wd2, we2,
    input  alu_out_mw, rd_mw, pc_mw, reg_write_mw, mem_to_reg_mw,
           load_npc_mw, load_data_mw, stall_req, rd2
`ifdef MISALIGN_TRAP_EN
    , input misalign_mw
`endif
  );

  modport slave (
    input  en, clear, alu_out_e, store_data_e, rd_e, pc_e, mem_write_e,
           reg_write_e, mem_to_reg_e, load_npc_e, a2, wd2, we2,
    output alu_out_mw, rd_mw, pc_mw, reg_write_mw, mem_to_reg_mw,
           load_npc_mw, load_data_mw, stall_req, rd2
`ifdef MISALIGN_TRAP_EN
    , output misalign_mw
`endif
  );
endinterface

// File: rtl/mem_wb_seg_reg_v2.sv
// MEM/WB segment register with integrated dual-port data RAM and load extension.
// Port A serves the pipeline, port B the debug path. READ_LAT selects 1- or
// 2-cycle RAM read latency; at 2 a one-cycle WAIT state stalls upstream.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned access trap).
module mem_wb_seg_reg_v2 #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned READ_LAT    = 1
) (
  input logic               clk,
  input logic               rst_n,
  mem_wb_seg_reg_v2_if.slave bus
);
  localparam int unsigned ADDR_W = $clog2(DEPTH_WORDS);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t            state, state_nx;
  logic              cap;
  logic              mis_e;
  logic [3:0]        wea;
  logic [ADDR_W-1:0] addr_a, addr_b;
  logic [XLEN-1:0]   mem [DEPTH_WORDS];
  logic [XLEN-1:0]   q1, q2, raw;
  logic [XLEN-1:0]   byte_sel, half_sel;
  logic              unused_addr_bits;

  assign addr_a = bus.alu_out_e[ADDR_W+1:2];
  assign addr_b = bus.a2[ADDR_W+1:2];
  assign unused_addr_bits = ^{bus.a2[XLEN-1:ADDR_W+2], bus.a2[1:0]};

  assign cap = (state == S_IDLE) && bus.en;

`ifdef MISALIGN_TRAP_EN
  logic is_half, is_word;
  // Classify access width: loads by reg_write code, stores by byte-enable pattern
  always_comb begin
    is_half = 1'b0;
    is_word = 1'b0;
    if (bus.mem_to_reg_e) begin
      is_half = (bus.reg_write_e == 3'b010) || (bus.reg_write_e == 3'b101);
      is_word = (bus.reg_write_e == 3'b011);
    end else begin
      is_half = (bus.mem_write_e == 4'b0011) || (bus.mem_write_e == 4'b1100);
      is_word = (bus.mem_write_e == 4'b1111);
    end
    mis_e = (is_half && bus.alu_out_e[0]) || (is_word && (bus.alu_out_e[1:0] != 2'b00));
  end
`else
  assign mis_e = 1'b0;
`endif

  assign wea = (cap && !bus.clear && !mis_e) ? bus.mem_write_e : '0;

  // RAM write: port B first so port A wins on lanes both ports enable
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (bus.we2[i]) mem[addr_b][i*8 +: 8] <= bus.wd2[i*8 +: 8];
      if (wea[i])     mem[addr_a][i*8 +: 8] <= bus.store_data_e[i*8 +: 8];
    end
  end

  // Read-first read pipeline; port A read is taken only on capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1      <= '0;
      q2      <= '0;
      bus.rd2 <= '0;
    end else begin
      if (cap) q1 <= mem[addr_a];
      q2      <= q1;
      bus.rd2 <= mem[addr_b];
    end
  end

  assign raw = (READ_LAT == 2) ? q2 : q1;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // FSM next state: only captured aligned loads at latency 2 enter WAIT
  always_comb begin
    state_nx = S_IDLE;
    if (state == S_IDLE && READ_LAT == 2 && cap && !bus.clear &&
        bus.mem_to_reg_e && !mis_e)
      state_nx = S_WAIT;
  end

  // FSM output
  always_comb begin
    bus.stall_req = (state == S_WAIT);
  end

  // Stage registers: capture in IDLE, hold in WAIT, clear zeroes in both
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.alu_out_mw    <= '0;
      bus.rd_mw         <= '0;
      bus.pc_mw         <= '0;
      bus.reg_write_mw  <= '0;
      bus.mem_to_reg_mw <= 1'b0;
      bus.load_npc_mw   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      bus.misalign_mw   <= 1'b0;
`endif
    end else if ((cap || state == S_WAIT) && bus.clear) begin
      bus.alu_out_mw    <= '0;
      bus.rd_mw         <= '0;
      bus.pc_mw         <= '0;
      bus.reg_write_mw  <= '0;
      bus.mem_to_reg_mw <= 1'b0;
      bus.load_npc_mw   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      bus.misalign_mw   <= 1'b0;
`endif
    end else if (cap) begin
      bus.alu_out_mw    <= bus.alu_out_e;
      bus.rd_mw         <= bus.rd_e;
      bus.pc_mw         <= bus.pc_e;
      bus.reg_write_mw  <= bus.reg_write_e;
      bus.mem_to_reg_mw <= bus.mem_to_reg_e;
      bus.load_npc_mw   <= bus.load_npc_e;
`ifdef MISALIGN_TRAP_EN
      bus.misalign_mw   <= mis_e;
`endif
    end
  end

  // Load extension on raw RAM data
  always_comb begin
    byte_sel = raw >> {bus.alu_out_mw[1:0], 3'b000};
    half_sel = raw >> {bus.alu_out_mw[1], 4'b0000};
    case (bus.reg_write_mw)
      3'b001:  bus.load_data_mw = {{(XLEN-8){byte_sel[7]}}, byte_sel[7:0]};
      3'b100:  bus.load_data_mw = {{(XLEN-8){1'b0}}, byte_sel[7:0]};
      3'b010:  bus.load_data_mw = {{(XLEN-16){half_sel[15]}}, half_sel[15:0]};
      3'b101:  bus.load_data_mw = {{(XLEN-16){1'b0}}, half_sel[15:0]};
      3'b011:  bus.load_data_mw = raw;
      default: bus.load_data_mw = '0;
    endcase
  end
endmodule

// File: tb/tb_mem_wb_seg_reg_v2.sv
// Self-checking bench: latency-1 and latency-2 instances driven in lockstep,
// checked against a word-array memory model and arithmetic load extension.
module tb_mem_wb_seg_reg_v2;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic        t_en, t_clear, t_m2r, t_npc;
  logic [31:0] t_alu, t_sd, t_pc, t_a2, t_wd2;
  logic [4:0]  t_rd;
  logic [3:0]  t_mw, t_we2;
  logic [2:0]  t_rw;

  mem_wb_seg_reg_v2_if #(.XLEN(32)) b1 ();
  mem_wb_seg_reg_v2_if #(.XLEN(32)) b2 ();

  mem_wb_seg_reg_v2 #(.XLEN(32), .DEPTH_WORDS(4096), .READ_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave));
  mem_wb_seg_reg_v2 #(.XLEN(32), .DEPTH_WORDS(4096), .READ_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(b2.slave));

  assign b1.en = t_en;           assign b2.en = t_en;
  assign b1.clear = t_clear;     assign b2.clear = t_clear;
  assign b1.alu_out_e = t_alu;   assign b2.alu_out_e = t_alu;
  assign b1.store_data_e = t_sd; assign b2.store_data_e = t_sd;
  assign b1.rd_e = t_rd;         assign b2.rd_e = t_rd;
  assign b1.pc_e = t_pc;         assign b2.pc_e = t_pc;
  assign b1.mem_write_e = t_mw;  assign b2.mem_write_e = t_mw;
  assign b1.reg_write_e = t_rw;  assign b2.reg_write_e = t_rw;
  assign b1.mem_to_reg_e = t_m2r; assign b2.mem_to_reg_e = t_m2r;
  assign b1.load_npc_e = t_npc;  assign b2.load_npc_e = t_npc;
  assign b1.a2 = t_a2;           assign b2.a2 = t_a2;
  assign b1.wd2 = t_wd2;         assign b2.wd2 = t_wd2;
  assign b1.we2 = t_we2;         assign b2.we2 = t_we2;

  // Memory model: words 0..63 (byte addresses 0..255)
  logic [31:0] mdl [64];

  function automatic logic [31:0] ext(input logic [31:0] w, input logic [2:0] rw,
                                      input int unsigned off);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (rw)
      3'd1: return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      3'd4: return b;
      3'd2: return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'd5: return h;
      3'd3: return w;
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    t_en = 0; t_clear = 0; t_mw = 0; t_rw = 0; t_m2r = 0; t_npc = 0; t_we2 = 0;
  endtask

  task automatic set_op(input logic [31:0] alu, input logic [3:0] mw, input logic [2:0] rw,
                        input logic m2r, input logic [31:0] sd, input logic [4:0] rd,
                        input logic [31:0] pc);
    t_en = 1; t_clear = 0; t_alu = alu; t_mw = mw; t_rw = rw; t_m2r = m2r;
    t_sd = sd; t_rd = rd; t_pc = pc; t_npc = 0;
  endtask

  task automatic model_store(input logic [31:0] addr, input logic [3:0] be,
                             input logic [31:0] d);
    for (int i = 0; i < 4; i++)
      if (be[i]) mdl[addr[7:2]][i*8 +: 8] = d[i*8 +: 8];
  endtask

  // Issue one op for a single cycle, then two bubbles so both latencies settle
  task automatic issue_load_check(input string tag, input logic [31:0] alu,
                                  input logic [2:0] rw, input logic [31:0] exp);
    set_op(alu, 4'h0, rw, 1'b1, 32'h0, 5'd1, 32'h100);
    tick();
    idle_inputs();
    tick();
    tick();
    chk({tag, "_lat1"}, b1.load_data_mw, exp);
    chk({tag, "_lat2"}, b2.load_data_mw, exp);
  endtask

  initial begin
    logic [31:0] exp, ra, addr, d, pc;
    logic [3:0]  be;
    logic [2:0]  rw;
    logic [4:0]  rd;
    int unsigned op;

    t_alu = 0; t_sd = 0; t_pc = 0; t_rd = 0; t_a2 = 0; t_wd2 = 0;
    idle_inputs();
    rst_n = 0;
    tick();
    tick();
    chk("rst_alu1", b1.alu_out_mw, 32'h0);
    chk("rst_rd2", {27'h0, b2.rd_mw}, 32'h0);
    chk("rst_pc1", b1.pc_mw, 32'h0);
    chk("rst_rw2", {29'h0, b2.reg_write_mw}, 32'h0);
    chk("rst_flags1", {30'h0, b1.mem_to_reg_mw, b1.load_npc_mw}, 32'h0);
    chk("rst_ld2", b2.load_data_mw, 32'h0);
    chk("rst_stall2", {31'h0, b2.stall_req}, 32'h0);
    rst_n = 1;

    // Preload model range through port B
    for (int i = 0; i < 64; i++) begin
      t_a2 = i * 4; t_wd2 = $urandom; t_we2 = 4'hF;
      mdl[i] = t_wd2;
      tick();
    end
    t_we2 = 0;

    // Asynchronous reset in the middle of WAIT
    set_op(32'h8, 4'h0, 3'd3, 1'b1, 32'h0, 5'd7, 32'h44);
    tick();
    idle_inputs();
    chk("wait_stall", {31'h0, b2.stall_req}, 32'h1);
    chk("wait_rd", {27'h0, b2.rd_mw}, 32'd7);
    #2 rst_n = 0;
    #1;
    chk("arst_stall", {31'h0, b2.stall_req}, 32'h0);
    chk("arst_alu", b2.alu_out_mw, 32'h0);
    chk("arst_rd", {27'h0, b2.rd_mw}, 32'h0);
    chk("arst_pc", b2.pc_mw, 32'h0);
    chk("arst_flags", {27'h0, b2.reg_write_mw, b2.mem_to_reg_mw, b2.load_npc_mw}, 32'h0);
    tick();
    rst_n = 1;
    tick();

    // Directed store and extension cases
    set_op(32'h10, 4'hF, 3'd0, 1'b0, 32'hDEADBEEF, 5'd0, 32'h200);
    model_store(32'h10, 4'hF, 32'hDEADBEEF);
    tick();
    idle_inputs();
    tick();
    issue_load_check("lb13", 32'h13, 3'd1, 32'hFFFF_FFDE);
    issue_load_check("lbu13", 32'h13, 3'd4, 32'h0000_00DE);
    issue_load_check("lh12", 32'h12, 3'd2, 32'hFFFF_DEAD);
    issue_load_check("lhu10", 32'h10, 3'd5, 32'h0000_BEEF);
    issue_load_check("lw_wrap", 32'hFFFF_C010, 3'd3, 32'hDEADBEEF);
    issue_load_check("alu_zero", 32'h10, 3'd6, 32'h0);

    // Back-to-back LW at latency 2: one WAIT each, rd_mw held through WAIT
    set_op(32'h10, 4'h0, 3'd3, 1'b1, 32'h0, 5'd5, 32'h300);
    tick();
    chk("b2b_stall_a", {31'h0, b2.stall_req}, 32'h1);
    chk("b2b_rd_a", {27'h0, b2.rd_mw}, 32'd5);
    t_rd = 5'd6; t_pc = 32'h304;
    tick();
    chk("b2b_stall_a_end", {31'h0, b2.stall_req}, 32'h0);
    chk("b2b_rd_held", {27'h0, b2.rd_mw}, 32'd5);
    chk("b2b_data_a", b2.load_data_mw, 32'hDEADBEEF);
    tick();
    chk("b2b_stall_b", {31'h0, b2.stall_req}, 32'h1);
    chk("b2b_rd_b", {27'h0, b2.rd_mw}, 32'd6);
    idle_inputs();
    tick();
    chk("b2b_stall_b_end", {31'h0, b2.stall_req}, 32'h0);
    chk("b2b_data_b", b2.load_data_mw, 32'hDEADBEEF);

    // Clear with a pending store: no write, stage zeroed
    set_op(32'h24, 4'hF, 3'd6, 1'b0, 32'h11111111, 5'd3, 32'h40);
    t_clear = 1;
    tick();
    idle_inputs();
    chk("clr_rd1", {27'h0, b1.rd_mw}, 32'h0);
    chk("clr_alu2", b2.alu_out_mw, 32'h0);
    chk("clr_pc1", b1.pc_mw, 32'h0);
    chk("clr_rw2", {29'h0, b2.reg_write_mw}, 32'h0);
    t_a2 = 32'h24;
    tick();
    chk("clr_nowrite1", b1.rd2, mdl[9]);
    chk("clr_nowrite2", b2.rd2, mdl[9]);

    // Clear during WAIT
    set_op(32'h10, 4'h0, 3'd3, 1'b1, 32'h0, 5'd9, 32'h500);
    tick();
    idle_inputs();
    t_clear = 1;
    tick();
    t_clear = 0;
    chk("wclr_rd", {27'h0, b2.rd_mw}, 32'h0);
    chk("wclr_stall", {31'h0, b2.stall_req}, 32'h0);

    // Concurrent A/B write to the same word: port A wins lane 0
    set_op(32'h20, 4'h1, 3'd0, 1'b0, 32'h000000AA, 5'd0, 32'h600);
    t_a2 = 32'h20; t_wd2 = 32'h12345678; t_we2 = 4'hF;
    mdl[8] = 32'h12345678;
    model_store(32'h20, 4'h1, 32'h000000AA);
    tick();
    idle_inputs();
    tick();
    chk("dual_wr1", b1.rd2, 32'h123456AA);
    chk("dual_wr2", b2.rd2, 32'h123456AA);

    // Randomized traffic against the model
    for (int n = 0; n < 40; n++) begin
      op = $urandom_range(0, 2);
      addr = $urandom_range(0, 255);
      d = $urandom;
      pc = $urandom;
      rd = 5'($urandom);
      if (op == 0) begin
        be = 4'($urandom);
        set_op(addr, be, 3'd0, 1'b0, d, rd, pc);
        model_store(addr, be, d);
        rw = 3'd0;
        exp = 32'h0;
      end else if (op == 1) begin
        rw = 3'($urandom_range(1, 5));
        set_op(addr, 4'h0, rw, 1'b1, d, rd, pc);
        exp = ext(mdl[addr[7:2]], rw, int'(addr[1:0]));
      end else begin
        rw = 3'd6;
        set_op(addr, 4'h0, rw, 1'b0, d, rd, pc);
        exp = 32'h0;
      end
      t_npc = 1'($urandom);
      tick();
      idle_inputs();
      ra = $urandom_range(0, 255);
      t_a2 = ra;
      tick();
      tick();
      chk("rnd_alu1", b1.alu_out_mw, addr);
      chk("rnd_pc2", b2.pc_mw, pc);
      chk("rnd_rd1", {27'h0, b1.rd_mw}, {27'h0, rd});
      chk("rnd_rw2", {29'h0, b2.reg_write_mw}, {29'h0, rw});
      chk("rnd_m2r2", {31'h0, b2.mem_to_reg_mw}, {31'h0, op == 1});
      chk("rnd_ld1", b1.load_data_mw, exp);
      chk("rnd_ld2", b2.load_data_mw, exp);
      chk("rnd_rd2_1", b1.rd2, mdl[ra[7:2]]);
      chk("rnd_rd2_2", b2.rd2, mdl[ra[7:2]]);
      chk("rnd_stall2", {31'h0, b2.stall_req}, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
